// File: rtl/mem_block_responder.sv
// -----------------------------------------------------------------------------
// mem_block_responder
//
// Memory-side responder for the cache block-transfer interface. It accepts one
// 128-bit block read or write at a time, spends LATENCY cycles in BUSY and then
// answers with a one-cycle registered mem_ready pulse. Read data is registered
// and holds until the next read completes.
//
// Parameters:
//   LATENCY   cycles spent in BUSY per request (1..15)
//   IDX_BITS  block-address bits used to index storage (depth 2^IDX_BITS)
//
// Ports:
//   clk         single clock, rising edge
//   proc_reset  asynchronous, active-high reset
//   mem_read    block read request (level, held until mem_ready)
//   mem_write   block write request (level, wins over mem_read)
//   mem_addr    28-bit block address (16-byte granularity)
//   mem_wdata   128-bit write block, word 0 in bits [31:0]
//   mem_rdata   128-bit registered read block
//   mem_ready   registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_block_responder #(
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned IDX_BITS = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
);

  localparam int         DEPTH    = 1 << IDX_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  accept_s;
  logic                  done_s;
  logic                  cnt_dec_s;
  logic [3:0]            cnt_r;
  logic [IDX_BITS-1:0]   idx_r;
  logic [127:0]          wdata_r;
  logic                  is_wr_r;
  logic [127:0]          rdata_r;
  logic                  ready_r;
  logic [127:0]          mem_r [DEPTH];

  // Upper address bits only alias onto the same entry; they carry no state.
  if (IDX_BITS < 28) begin : g_alias
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^mem_addr[27:IDX_BITS];
  end

  // State register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    cnt_dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Inputs are not looked at here: the latched request is completed
        // even if the requester drops it.
        if (cnt_r == 4'd0) begin
          done_s      = 1'b1;
          state_nxt_s = ST_READY;
        end else begin
          cnt_dec_s   = 1'b1;
          state_nxt_s = ST_BUSY;
        end
      end
      ST_READY: begin
        // Requester still holds its request during this cycle; ignore it.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Latency counter: loaded on acceptance, counts down while busy.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= CNT_INIT;
    end else if (cnt_dec_s) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Request latch: index, write data and operation captured at acceptance.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      idx_r   <= '0;
      wdata_r <= 128'd0;
      is_wr_r <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= mem_addr[IDX_BITS-1:0];
      wdata_r <= mem_wdata;
      is_wr_r <= mem_write;  // write wins when both are requested
    end else begin
      idx_r   <= idx_r;
      wdata_r <= wdata_r;
      is_wr_r <= is_wr_r;
    end
  end

  // Block storage; an aborted write never reaches it because reset wins.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 128'd0;
      end
    end else if (done_s && is_wr_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Read data register; only a completing read updates it.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      rdata_r <= 128'd0;
    end else if (done_s && !is_wr_r) begin
      rdata_r <= mem_r[idx_r];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Completion pulse, high for the READY cycle only.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= done_s;
    end
  end

  assign mem_rdata = rdata_r;
  assign mem_ready = ready_r;

endmodule

// File: tb/tb_mem_block_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_block_responder
//
// Self-checking bench for mem_block_responder (LATENCY=4, IDX_BITS=8).
// A transaction-level model (acceptance times, completion times, an array of
// blocks) predicts mem_ready and mem_rdata; a negedge process compares them
// every cycle. Directed scenarios add hand-computed expectations, followed by
// a randomized request phase.
// -----------------------------------------------------------------------------
module tb_mem_block_responder;

  localparam int LAT  = 4;
  localparam int IDX  = 8;
  localparam int NENT = 256;

  logic         clk;
  logic         proc_reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int total;
  int bad;
  bit chk_on;

  mem_block_responder #(.LATENCY(LAT), .IDX_BITS(IDX)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int           m_cyc;       // edges since reset
  int           m_free_at;   // first edge at which a new request may be accepted
  int           m_ready_at;  // edge at which the pending request completes
  bit           m_pend;
  bit           m_is_wr;
  int           m_idx;
  logic [127:0] m_data;
  logic [127:0] m_rdata;
  logic         m_exp_ready;
  logic [127:0] m_mem [NENT];

  always @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      m_cyc       <= 0;
      m_free_at   <= 0;
      m_ready_at  <= 0;
      m_pend      <= 1'b0;
      m_exp_ready <= 1'b0;
      m_rdata     <= 128'd0;
      for (int i = 0; i < NENT; i++) m_mem[i] <= 128'd0;
    end else begin
      m_cyc       <= m_cyc + 1;
      m_exp_ready <= m_pend && (m_cyc == m_ready_at);
      if (m_pend && m_cyc == m_ready_at) begin
        m_pend <= 1'b0;
        if (m_is_wr) m_mem[m_idx] <= m_data;
        else         m_rdata <= m_mem[m_idx];
      end
      if (!m_pend && m_cyc >= m_free_at && (mem_read || mem_write)) begin
        m_pend     <= 1'b1;
        m_ready_at <= m_cyc + LAT;
        m_free_at  <= m_cyc + LAT + 2;
        m_is_wr    <= mem_write;
        m_idx      <= int'(mem_addr % 28'(NENT));
        m_data     <= mem_wdata;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_on && !proc_reset) begin
      chk("cyc_ready", {127'd0, mem_ready}, {127'd0, m_exp_ready});
      chk("cyc_rdata", mem_rdata, m_rdata);
    end
  end

  // ---------------- directed helpers ----------------
  // Starts just after a negedge; raises the request, waits for mem_ready,
  // drops the request, and samples rdata at ready and one cycle later.
  task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input int drop_at,
                     output int lat, output logic [127:0] r0, output logic [127:0] r1);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (mem_ready) begin
        lat = k;
        break;
      end
    end
    r0 = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    r1 = mem_rdata;
  endtask

  localparam logic [127:0] BLK = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DAT_A = 128'hAAAA5555_0000FFFF_12345678_9ABCDEF0;
  localparam logic [127:0] DAT_B = 128'hBBBB0000_CAFEF00D_DEADBEEF_00C0FFEE;
  localparam logic [127:0] DAT_C = 128'hCCCC_CCCC_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DAT_D = 128'hD0D0D0D0_0D0D0D0D_F00DFACE_01020304;

  int           lat;
  logic [127:0] r0;
  logic [127:0] r1;
  int           npulse;
  int           first_k;
  int           last_k;

  initial begin
    total = 0;
    bad = 0;
    chk_on = 1'b0;
    proc_reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = 28'd0;
    mem_wdata = 128'd0;
    repeat (3) @(negedge clk);
    proc_reset = 1'b0;
    chk_on = 1'b1;

    // Fresh storage reads back zero.
    txn(1'b1, 1'b0, 28'h5, 128'd0, 0, lat, r0, r1);
    chk("rst_read_lat", 128'(lat), 128'd5);
    chk("rst_read_data", r0, 128'd0);

    // Write then read back.
    txn(1'b0, 1'b1, 28'h12, BLK, 0, lat, r0, r1);
    chk("wr_lat", 128'(lat), 128'd5);
    txn(1'b1, 1'b0, 28'h12, 128'd0, 0, lat, r0, r1);
    chk("rd_lat", 128'(lat), 128'd5);
    chk("rd_data", r0, BLK);
    chk("rd_data_hold", r1, BLK);

    // Asynchronous reset between clock edges clears outputs at once.
    @(posedge clk);
    #2;
    proc_reset = 1'b1;
    #1;
    chk("async_ready", {127'd0, mem_ready}, 128'd0);
    chk("async_rdata", mem_rdata, 128'd0);
    @(negedge clk);
    proc_reset = 1'b0;
    txn(1'b1, 1'b0, 28'h5, 128'd0, 0, lat, r0, r1);
    chk("post_rst_read", r0, 128'd0);
    txn(1'b1, 1'b0, 28'h12, 128'd0, 0, lat, r0, r1);
    chk("post_rst_cleared", r0, 128'd0);

    // Held read: one pulse per LAT+2 cycles, none right after READY.
    mem_read = 1'b1;
    mem_addr = 28'h12;
    npulse = 0;
    first_k = -1;
    last_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        npulse++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
    end
    mem_read = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_pulses", 128'(npulse), 128'd3);
    chk("held_first", 128'(first_k), 128'd5);
    chk("held_last", 128'(last_k), 128'd17);

    // Simultaneous read+write: write wins, rdata untouched.
    txn(1'b0, 1'b1, 28'h20, DAT_D, 0, lat, r0, r1);
    txn(1'b1, 1'b0, 28'h20, 128'd0, 0, lat, r0, r1);
    chk("pre_both_rdata", r0, DAT_D);
    txn(1'b1, 1'b1, 28'h3, DAT_A, 0, lat, r0, r1);
    chk("both_lat", 128'(lat), 128'd5);
    chk("both_rdata_kept", r0, DAT_D);
    txn(1'b1, 1'b0, 28'h3, 128'd0, 0, lat, r0, r1);
    chk("both_readback", r0, DAT_A);

    // Aliasing of upper address bits.
    txn(1'b0, 1'b1, 28'h0000100, DAT_B, 0, lat, r0, r1);
    txn(1'b1, 1'b0, 28'h0000000, 128'd0, 0, lat, r0, r1);
    chk("alias_read", r0, DAT_B);

    // Read dropped one cycle after acceptance still completes.
    txn(1'b0, 1'b1, 28'h0000000, DAT_A, 0, lat, r0, r1);
    txn(1'b1, 1'b0, 28'h0FFFF00, 128'd0, 1, lat, r0, r1);
    chk("drop_lat", 128'(lat), 128'd5);
    chk("drop_data", r0, DAT_A);

    // Reset during a write's BUSY phase aborts it.
    mem_write = 1'b1;
    mem_addr = 28'h7;
    mem_wdata = DAT_C;
    repeat (2) @(negedge clk);
    proc_reset = 1'b1;
    mem_write = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_ready) npulse++;
    end
    chk("abort_no_ready", 128'(npulse), 128'd0);
    txn(1'b1, 1'b0, 28'h7, 128'd0, 0, lat, r0, r1);
    chk("abort_read", r0, 128'd0);

    // Randomized requests checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = ($urandom_range(0, 3) == 0);
        mem_addr  = {20'($urandom()), 4'h0, 4'($urandom())};
        mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
